item_table_gen: RTL and testbench
=================================

Name: item_table_gen

Overview:
Parametrised item table for the mining playfield. It draws up to MAX_ITEMS non-overlapping grid positions from an LFSR, with a sequential collision check. It then serves N_CH independent move/update channels over a valid/ready handshake, using saturating coordinate arithmetic. The table is exported flat to the renderer and to the hook/collision logic.

Parameters:
MAX_ITEMS, 32, table depth; IDX_W = clog2(MAX_ITEMS)
N_CH, 2, number of move channels
X_W, 13, x field width
Y_W, 12, y field width
X_SHIFT, 8, left shift applied to the x grid cell
Y_SHIFT, 8, left shift applied to the y grid cell
GRID_X, 20, number of x cells
GRID_Y, 10, number of y cells
RETRY_MAX, 64, consecutive collisions allowed before generation aborts
SEED, 16'hACE1, LFSR reset value (must be non-zero)

Ports:
clock  in  1  system clock
resetn  in  1  reset
gen_start  in  1  one-cycle pulse; starts generation
quantity  in  IDX_W+1  number of items requested
gen_busy  out  1  high while generating
gen_done  out  1  one-cycle pulse when generation ends
gen_fail  out  1  latched high if generation aborted on RETRY_MAX
count  out  IDX_W+1  number of valid entries
mv_valid  in  N_CH  per-channel request
mv_ready  out  N_CH  per-channel accept
mv_index  in  N_CH*IDX_W  target entry per channel
mv_dx  in  N_CH*X_W  signed two's-complement x delta
mv_dy  in  N_CH*Y_W  signed two's-complement y delta
mv_moved  in  N_CH  new moved bit
mv_visible  in  N_CH  new visible bit
data  out  MAX_ITEMS*ENTRY_W  flat table; ENTRY_W = X_W+Y_W+7

Behaviour:
- Interface: one clock, clock; reset is asynchronous and active-low, resetn.
- Entry n layout, LSB-first:
  - bit 0: moved
  - bit 1: visible
  - bits 6:2: type/extension
  - next Y_W bits: y
  - top X_W bits: x
- Reset values: data=0, count=0, gen_busy=0, gen_done=0, gen_fail=0, LFSR=SEED, FSM=IDLE.
- mv_ready is all-ones in IDLE. Reset mid-operation clears everything immediately; no partial commits survive.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It advances only in DRAW.
- FSM states: IDLE, CLEAR, DRAW, CHECK, COMMIT, DONE.
  - IDLE, gen_start=1 -> CLEAR. gen_start is ignored in any other state.
  - CLEAR (1 cycle): data=0, count=0, gen_fail=0, target = min(quantity, MAX_ITEMS). Target 0 -> DONE, else -> DRAW.
  - DRAW (1 cycle): candidate x = (lfsr[15:8] % GRID_X) << X_SHIFT, candidate y = (lfsr[7:0] % GRID_Y) << Y_SHIFT.
  - CHECK: compare the candidate against entry j, one entry per cycle, j = 0..count-1.
    - Match: retry counter +1, then -> DRAW. If the retry counter reaches RETRY_MAX, set gen_fail=1 and -> DONE.
    - j == count: -> COMMIT.
  - COMMIT (1 cycle): write entry[count] = {x, y, 5'b0, visible=1, moved=0}, count+1, retry counter=0. count==target -> DONE, else -> DRAW.
  - DONE (1 cycle): gen_done=1, then -> IDLE.
- gen_busy=1 in every state except IDLE. mv_ready=0 while gen_busy.
- Move handshake:
  - A transfer occurs when mv_valid[c] & mv_ready[c]. The entry is updated on the next clock edge (latency 1).
  - x_new = clamp(x+dx, 0, 2^X_W-1); y likewise. Compute at width X_W+1 / Y_W+1, then saturate.
  - moved and visible are overwritten with mv_moved / mv_visible.
- Simultaneous move events:
  - Distinct indices on different channels in the same cycle are all applied.
  - If two or more valid channels target the same index, the lowest channel wins. Higher channels see mv_ready=0 that cycle and must hold their request.
  - mv_index >= count: accepted and discarded; the table is unchanged.

Optional Feature:
ITEM_TYPE_EN
- Defined: COMMIT writes bits [3:2] of entry n from its index band: n<8 -> 2'b00 gold, n<16 -> 2'b01 stone, otherwise 2'b10 diamond. Bits [6:4] = 0. Move updates preserve bits [6:2].
- Undefined: bits [6:2] are always 0.

Decomposition:
- Package item_pkg holds: the ENTRY_W function, field offset constants, the type encodings, and an FSM state enum.
- One sub-module, item_lfsr16: LFSR with enable and async reset, reusable by the score and level blocks.

Test Plan:
1. resetn=0 mid-CHECK with count=3 -> data=0, count=0, gen_busy=0 asynchronously, before the next edge.
2. gen_start, quantity=5 -> one gen_done pulse; count=5; all five (x,y) pairs distinct; each x>>8 < 20 and y>>8 < 10; visible=1, moved=0; gen_fail=0.
3. Channel 0: index 2, dx=+3, dy=-1 -> after one cycle, entry 2 has x+3 and y-1; all other entries unchanged.
4. Entry x=0, dx=-5 -> x=0. Entry x=8190, dx=+9 -> x=8191.
5. Both channels valid with index 4 -> mv_ready=2'b01; channel 0 delta applied first; channel 1 applied the following cycle.
6. GRID_X=2, GRID_Y=2, quantity=6 -> count=4, gen_fail=1, gen_done pulse. Separately, quantity=40 at MAX_ITEMS=32 -> count=32.

Source files
------------

// File: rtl/item_pkg.sv
// Item table shared definitions: entry layout, type codes, generator states.
// Used by item_table_gen and item_lfsr16.
package item_pkg;

   localparam int FLD_MOVED = 0;
   localparam int FLD_VIS   = 1;
   localparam int FLD_TYPE  = 2;
   localparam int TYPE_W    = 5;
   localparam int FLD_Y     = FLD_TYPE + TYPE_W;

   localparam logic [1:0] TYPE_GOLD    = 2'b00;
   localparam logic [1:0] TYPE_STONE   = 2'b01;
   localparam logic [1:0] TYPE_DIAMOND = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_DRAW,
      S_CHECK,
      S_COMMIT,
      S_DONE
   } gen_state_t;

   function automatic int entry_w(input int xw, input int yw);
      return xw + yw + TYPE_W + 2;
   endfunction

   // Type band by table index: low indices gold, then stone, then diamond.
   function automatic logic [TYPE_W-1:0] band_type(input int n);
      logic [1:0] t;
      if (n < 8)       t = TYPE_GOLD;
      else if (n < 16) t = TYPE_STONE;
      else             t = TYPE_DIAMOND;
      return {3'b000, t};
   endfunction

endpackage

// File: rtl/item_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11), advances when en is high.
// Ports: clock, resetn (async low), en, value (current state).
module item_lfsr16
   import item_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        en,
   output logic [15:0] value
);

   logic [15:0] q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         q <= SEED;
      end else if (en) begin
         q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
      end
   end

   assign value = q;

endmodule

// File: rtl/item_table_gen.sv
// Item table: LFSR placement with collision retry, then N_CH move channels.
// Ports: clock/resetn, gen_* control, count, mv_* handshake, flat data. Macro: ITEM_TYPE_EN.
module item_table_gen
   import item_pkg::*;
#(
   parameter int          MAX_ITEMS = 32,
   parameter int          N_CH      = 2,
   parameter int          X_W       = 13,
   parameter int          Y_W       = 12,
   parameter int          X_SHIFT   = 8,
   parameter int          Y_SHIFT   = 8,
   parameter int          GRID_X    = 20,
   parameter int          GRID_Y    = 10,
   parameter int          RETRY_MAX = 64,
   parameter logic [15:0] SEED      = 16'hACE1,
   localparam int         IDX_W     = $clog2(MAX_ITEMS),
   localparam int         ENTRY_W   = entry_w(X_W, Y_W)
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic                         gen_start,
   input  logic [IDX_W:0]               quantity,
   output logic                         gen_busy,
   output logic                         gen_done,
   output logic                         gen_fail,
   output logic [IDX_W:0]               count,
   input  logic [N_CH-1:0]              mv_valid,
   output logic [N_CH-1:0]              mv_ready,
   input  logic [N_CH*IDX_W-1:0]        mv_index,
   input  logic [N_CH*X_W-1:0]          mv_dx,
   input  logic [N_CH*Y_W-1:0]          mv_dy,
   input  logic [N_CH-1:0]              mv_moved,
   input  logic [N_CH-1:0]              mv_visible,
   output logic [MAX_ITEMS*ENTRY_W-1:0] data
);

   localparam int             X_LSB   = FLD_Y + Y_W;
   localparam int             RW      = $clog2(RETRY_MAX + 1);
   localparam logic [IDX_W:0] MAX_CNT = (IDX_W + 1)'(MAX_ITEMS);
   localparam logic [RW-1:0]  R_LAST  = RW'(RETRY_MAX - 1);

   gen_state_t        state;
   logic [ENTRY_W-1:0] tbl [MAX_ITEMS];
   logic [IDX_W:0]    count_q;
   logic [IDX_W:0]    target;
   logic [IDX_W:0]    scan;
   logic [RW-1:0]     retry;
   logic [X_W-1:0]    cand_x;
   logic [Y_W-1:0]    cand_y;
   logic              fail_q;
   logic [15:0]       lfsr;

   item_lfsr16 #(.SEED(SEED)) u_lfsr (
      .clock  (clock),
      .resetn (resetn),
      .en     (state == S_DRAW),
      .value  (lfsr)
   );

   // Candidate cell from the current LFSR word.
   logic [7:0]     cell_x;
   logic [7:0]     cell_y;
   logic [IDX_W:0] tgt;
   logic           hit;
   logic [TYPE_W-1:0] new_type;

   always_comb begin
      cell_x = lfsr[15:8] % 8'(GRID_X);
      cell_y = lfsr[7:0] % 8'(GRID_Y);
      tgt    = (quantity > MAX_CNT) ? MAX_CNT : quantity;
      hit    = (tbl[scan[IDX_W-1:0]][X_LSB +: X_W] == cand_x) &&
               (tbl[scan[IDX_W-1:0]][FLD_Y +: Y_W] == cand_y);
`ifdef ITEM_TYPE_EN
      new_type = band_type(int'(count_q));
`else
      new_type = '0;
`endif
   end

   // Move channels: arbitration and saturating update values.
   logic [IDX_W-1:0]   idx  [N_CH];
   logic [ENTRY_W-1:0] upd  [N_CH];
   logic [N_CH-1:0]    fire;
   logic [N_CH-1:0]    in_rng;

   always_comb begin
      logic [ENTRY_W-1:0] old;
      logic [X_W+1:0]     sx;
      logic [Y_W+1:0]     sy;
      logic [X_W-1:0]     dx;
      logic [Y_W-1:0]     dy;
      logic [X_W-1:0]     nx;
      logic [Y_W-1:0]     ny;
      logic [TYPE_W-1:0]  keep;
      old      = '0;
      sx       = '0;
      sy       = '0;
      dx       = '0;
      dy       = '0;
      nx       = '0;
      ny       = '0;
      keep     = '0;
      mv_ready = '0;
      fire     = '0;
      in_rng   = '0;
      for (int c = 0; c < N_CH; c++) begin
         idx[c] = mv_index[c*IDX_W +: IDX_W];
         upd[c] = '0;
      end
      for (int c = 0; c < N_CH; c++) begin
         mv_ready[c] = (state == S_IDLE);
         // A lower channel aiming at the same entry wins this cycle.
         for (int b = 0; b < c; b++) begin
            if (mv_valid[b] && idx[b] == idx[c]) mv_ready[c] = 1'b0;
         end
         fire[c]   = mv_valid[c] & mv_ready[c];
         in_rng[c] = {1'b0, idx[c]} < count_q;
         old = tbl[idx[c]];
         dx  = mv_dx[c*X_W +: X_W];
         dy  = mv_dy[c*Y_W +: Y_W];
         // Two extra bits: top one flags negative, next flags overflow.
         sx  = {2'b00, old[X_LSB +: X_W]} + {{2{dx[X_W-1]}}, dx};
         sy  = {2'b00, old[FLD_Y +: Y_W]} + {{2{dy[Y_W-1]}}, dy};
         if (sx[X_W+1])    nx = '0;
         else if (sx[X_W]) nx = '1;
         else              nx = sx[X_W-1:0];
         if (sy[Y_W+1])    ny = '0;
         else if (sy[Y_W]) ny = '1;
         else              ny = sy[Y_W-1:0];
`ifdef ITEM_TYPE_EN
         keep = old[FLD_TYPE +: TYPE_W];
`else
         keep = '0;
`endif
         upd[c] = {nx, ny, keep, mv_visible[c], mv_moved[c]};
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state   <= S_IDLE;
         count_q <= '0;
         target  <= '0;
         scan    <= '0;
         retry   <= '0;
         cand_x  <= '0;
         cand_y  <= '0;
         fail_q  <= 1'b0;
         for (int n = 0; n < MAX_ITEMS; n++) tbl[n] <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (gen_start) state <= S_CLEAR;
               for (int c = 0; c < N_CH; c++) begin
                  if (fire[c] && in_rng[c]) tbl[idx[c]] <= upd[c];
               end
            end
            S_CLEAR: begin
               for (int n = 0; n < MAX_ITEMS; n++) tbl[n] <= '0;
               count_q <= '0;
               fail_q  <= 1'b0;
               retry   <= '0;
               target  <= tgt;
               state   <= (tgt == '0) ? S_DONE : S_DRAW;
            end
            S_DRAW: begin
               cand_x <= X_W'(cell_x) << X_SHIFT;
               cand_y <= Y_W'(cell_y) << Y_SHIFT;
               scan   <= '0;
               state  <= S_CHECK;
            end
            S_CHECK: begin
               if (scan == count_q) begin
                  state <= S_COMMIT;
               end else if (hit) begin
                  retry <= retry + 1'b1;
                  if (retry == R_LAST) begin
                     fail_q <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     state <= S_DRAW;
                  end
               end else begin
                  scan <= scan + 1'b1;
               end
            end
            S_COMMIT: begin
               tbl[count_q[IDX_W-1:0]] <= {cand_x, cand_y, new_type, 1'b1, 1'b0};
               count_q <= count_q + 1'b1;
               retry   <= '0;
               state   <= (count_q + 1'b1 == target) ? S_DONE : S_DRAW;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign gen_busy = (state != S_IDLE);
   assign gen_done = (state == S_DONE);
   assign gen_fail = fail_q;
   assign count    = count_q;

   for (genvar n = 0; n < MAX_ITEMS; n++) begin : g_flat
      assign data[n*ENTRY_W +: ENTRY_W] = tbl[n];
   end

endmodule

// File: tb/tb_item_table_gen.sv
// Directed bench for item_table_gen: reset, generation, moves, saturation,
// arbitration, retry abort on a tiny grid and quantity clamping.
module tb_item_table_gen;

   localparam int EW = 32;

   int total = 0;
   int bad   = 0;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   always #5 clock = ~clock;

   logic        start_a = 1'b0;
   logic [5:0]  qty_a   = '0;
   logic        busy_a, done_a, fail_a;
   logic [5:0]  cnt_a;
   logic [1:0]  mvv_a   = '0;
   logic [1:0]  mvr_a;
   logic [9:0]  mvi_a   = '0;
   logic [25:0] mvdx_a  = '0;
   logic [23:0] mvdy_a  = '0;
   logic [1:0]  mvm_a   = '0;
   logic [1:0]  mvvis_a = '0;
   logic [1023:0] data_a;

   logic        start_b = 1'b0;
   logic [5:0]  qty_b   = '0;
   logic        busy_b, done_b, fail_b;
   logic [5:0]  cnt_b;
   logic [1:0]  mvv_b   = '0;
   logic [1:0]  mvr_b;
   logic [9:0]  mvi_b   = '0;
   logic [25:0] mvdx_b  = '0;
   logic [23:0] mvdy_b  = '0;
   logic [1:0]  mvm_b   = '0;
   logic [1:0]  mvvis_b = '0;
   logic [1023:0] data_b;

   item_table_gen dut_a (
      .clock(clock), .resetn(resetn),
      .gen_start(start_a), .quantity(qty_a),
      .gen_busy(busy_a), .gen_done(done_a), .gen_fail(fail_a),
      .count(cnt_a),
      .mv_valid(mvv_a), .mv_ready(mvr_a), .mv_index(mvi_a),
      .mv_dx(mvdx_a), .mv_dy(mvdy_a),
      .mv_moved(mvm_a), .mv_visible(mvvis_a),
      .data(data_a)
   );

   item_table_gen #(.GRID_X(2), .GRID_Y(2)) dut_b (
      .clock(clock), .resetn(resetn),
      .gen_start(start_b), .quantity(qty_b),
      .gen_busy(busy_b), .gen_done(done_b), .gen_fail(fail_b),
      .count(cnt_b),
      .mv_valid(mvv_b), .mv_ready(mvr_b), .mv_index(mvi_b),
      .mv_dx(mvdx_b), .mv_dy(mvdy_b),
      .mv_moved(mvm_b), .mv_visible(mvvis_b),
      .data(data_b)
   );

   // Expected table contents.
   int ex [32];
   int ey [32];
   bit emv [32];
   bit evis [32];

   task automatic check_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      logic [15:0] r;
      r = l >> 1;
      if (l[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   // Reference placement from the reset seed on the 20x10 grid.
   task automatic model_gen(input int q);
      logic [15:0] l;
      int n, retry, cx, cy;
      bit h;
      l = 16'hACE1;
      n = 0;
      retry = 0;
      for (int i = 0; i < 32; i++) begin
         ex[i] = 0; ey[i] = 0; emv[i] = 0; evis[i] = 0;
      end
      while (n < q && retry < 64) begin
         cx = (int'(l[15:8]) % 20) * 256;
         cy = (int'(l[7:0]) % 10) * 256;
         l  = lfsr_step(l);
         h  = 0;
         for (int j = 0; j < n; j++)
            if (ex[j] == cx && ey[j] == cy) h = 1;
         if (h) begin
            retry++;
         end else begin
            ex[n] = cx; ey[n] = cy; evis[n] = 1; emv[n] = 0;
            n++;
            retry = 0;
         end
      end
   endtask

   function automatic logic [31:0] ent(input int i);
      return {13'(ex[i]), 12'(ey[i]), 5'b00000, evis[i], emv[i]};
   endfunction

   task automatic check_table(input string tag);
      for (int i = 0; i < 32; i++)
         check_eq($sformatf("%s[%0d]", tag, i), data_a[i*EW +: EW], ent(i));
   endtask

   // Distinctness and grid-range check on the DUT's first n entries.
   task automatic check_layout(input string tag, input int n);
      bit err;
      logic [12:0] xi, xj;
      logic [11:0] yi, yj;
      err = 0;
      for (int i = 0; i < n; i++) begin
         xi = data_a[i*EW+19 +: 13];
         yi = data_a[i*EW+7 +: 12];
         if (xi[7:0] != 0 || (xi >> 8) >= 20) err = 1;
         if (yi[7:0] != 0 || (yi >> 8) >= 10) err = 1;
         if (data_a[i*EW +: 7] != 7'b0000010) err = 1;
         for (int j = i + 1; j < n; j++) begin
            xj = data_a[j*EW+19 +: 13];
            yj = data_a[j*EW+7 +: 12];
            if (xi == xj && yi == yj) err = 1;
         end
      end
      check_eq(tag, err, 0);
   endtask

   task automatic wait_done_a(input int budget, output bit seen);
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         tick;
         if (done_a) begin
            seen = 1;
            break;
         end
      end
   endtask

   task automatic move_a(input int ch, input int idx, input int dx,
                         input int dy, input bit m, input bit v);
      bit ok;
      mvi_a[ch*5 +: 5]    = 5'(idx);
      mvdx_a[ch*13 +: 13] = 13'(dx);
      mvdy_a[ch*12 +: 12] = 12'(dy);
      mvm_a[ch]   = m;
      mvvis_a[ch] = v;
      mvv_a[ch]   = 1'b1;
      #1;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (mvr_a[ch]) begin
            ok = 1;
            break;
         end
         tick;
         #1;
      end
      check_eq("mv_accept", ok, 1);
      tick;
      mvv_a[ch] = 1'b0;
   endtask

   initial begin
      bit seen;
      int x4;

      // Reset state.
      #1;
      check_eq("rst_busy", busy_a, 0);
      check_eq("rst_done", done_a, 0);
      check_eq("rst_fail", fail_a, 0);
      check_eq("rst_count", cnt_a, 0);
      check_eq("rst_data", |data_a, 0);
      check_eq("rst_ready", mvr_a, 2'b11);
      tick;
      resetn = 1'b1;
      tick;

      // Async reset during a collision scan with three entries committed.
      qty_a = 6'd10;
      start_a = 1'b1;
      tick;
      start_a = 1'b0;
      seen = 0;
      for (int i = 0; i < 2000; i++) begin
         if (cnt_a == 6'd3) begin
            seen = 1;
            break;
         end
         tick;
      end
      check_eq("mid_count3", seen, 1);
      tick;
      #2;
      resetn = 1'b0;
      #1;
      check_eq("arst_data", |data_a, 0);
      check_eq("arst_count", cnt_a, 0);
      check_eq("arst_busy", busy_a, 0);
      tick;
      resetn = 1'b1;
      tick;

      // Generate five items from the seed.
      model_gen(5);
      qty_a = 6'd5;
      start_a = 1'b1;
      tick;
      start_a = 1'b0;
      check_eq("gen_busy", busy_a, 1);
      check_eq("gen_noready", mvr_a, 2'b00);
      wait_done_a(3000, seen);
      check_eq("gen5_done", seen, 1);
      check_eq("gen5_count", cnt_a, 5);
      check_eq("gen5_fail", fail_a, 0);
      tick;
      check_eq("gen5_pulse", done_a, 0);
      check_eq("gen5_idle", busy_a, 0);
      check_eq("idle_ready", mvr_a, 2'b11);
      check_layout("gen5_layout", 5);
      check_table("gen5");

      // Channel 0 moves entry 2 by (+3, -1).
      move_a(0, 2, 3, -1, 1'b0, 1'b1);
      ex[2] = ex[2] + 3;
      ey[2] = (ey[2] > 0) ? ey[2] - 1 : 0;
      emv[2] = 0;
      evis[2] = 1;
      check_table("mv2");

      // Saturation at both ends of x on entry 0 via channel 1.
      move_a(1, 0, -4096, 0, 1'b1, 1'b1);
      move_a(1, 0, -4096, 0, 1'b1, 1'b1);
      ex[0] = 0; emv[0] = 1; evis[0] = 1;
      check_eq("sat_lo0", data_a[0 +: EW], ent(0));
      move_a(1, 0, -5, 0, 1'b1, 1'b1);
      check_eq("sat_lo", data_a[0 +: EW], ent(0));
      move_a(1, 0, 4095, 0, 1'b1, 1'b1);
      move_a(1, 0, 4095, 0, 1'b1, 1'b1);
      ex[0] = 8190;
      check_eq("x_8190", data_a[0 +: EW], ent(0));
      move_a(1, 0, 9, 0, 1'b1, 1'b1);
      ex[0] = 8191;
      check_eq("sat_hi", data_a[0 +: EW], ent(0));

      // Both channels target entry 4: channel 0 first, channel 1 next.
      x4 = ex[4];
      mvi_a = {5'd4, 5'd4};
      mvdx_a = {13'd2, 13'd1};
      mvdy_a = '0;
      mvm_a = 2'b01;
      mvvis_a = 2'b01;
      mvv_a = 2'b11;
      #1;
      check_eq("arb_ready", mvr_a, 2'b01);
      tick;
      ex[4] = x4 + 1; emv[4] = 1; evis[4] = 1;
      check_eq("arb_ch0", data_a[4*EW +: EW], ent(4));
      mvv_a[0] = 1'b0;
      #1;
      check_eq("arb_ready2", mvr_a, 2'b11);
      tick;
      mvv_a = 2'b00;
      ex[4] = x4 + 3; emv[4] = 0; evis[4] = 0;
      check_eq("arb_ch1", data_a[4*EW +: EW], ent(4));

      // Index beyond count is accepted and dropped.
      move_a(0, 7, 100, 100, 1'b1, 1'b1);
      check_table("oob");
      check_eq("oob_count", cnt_a, 5);

      // Quantity above table depth is clamped.
      qty_a = 6'd40;
      start_a = 1'b1;
      tick;
      start_a = 1'b0;
      wait_done_a(40000, seen);
      check_eq("q40_done", seen, 1);
      check_eq("q40_count", cnt_a, 32);
      check_eq("q40_fail", fail_a, 0);
      check_layout("q40_layout", 32);

      // 2x2 grid holds only four items; the fifth aborts on retries.
      qty_b = 6'd6;
      start_b = 1'b1;
      tick;
      start_b = 1'b0;
      seen = 0;
      for (int i = 0; i < 5000; i++) begin
         tick;
         if (done_b) begin
            seen = 1;
            break;
         end
      end
      check_eq("grid2_done", seen, 1);
      check_eq("grid2_count", cnt_b, 4);
      check_eq("grid2_fail", fail_b, 1);
      tick;
      check_eq("grid2_idle", busy_b, 0);
      check_eq("grid2_fail_held", fail_b, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
